// File: rtl/alu_sequencer.sv
// alu_sequencer
// Multi-cycle control sequencer for the ALU register-transfer instructions.
// It accepts one decoded instruction on a start handshake, then steps the
// shared-bus datapath through operand fetch into Y, ALU execute into Z, and
// writeback of Z to the register file (or to LO/HI for multiply/divide).
// At most one instruction is in flight; start is only honoured in IDLE.
//
// Ports:
//   clock         system clock, rising edge
//   clear         synchronous active-low reset
//   start         request to execute (accepted only in IDLE)
//   opcode        ALU opcode of the instruction
//   ra/rb/rc      destination / source 1 / source 2 register fields
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
//   illegal       qualifies done: opcode was above OP_MAX
//   rf_read_sel   register driven onto the bus (0 when rf_read_en low)
//   rf_read_en    register-file bus drive enable
//   y_load        load Y from the bus
//   alu_opcode    opcode presented to the ALU (last accepted opcode)
//   z_load        load Z from the ALU result
//   z_lo_out      drive Z[31:0] onto the bus
//   z_hi_out      drive Z[63:32] onto the bus
//   rf_write_sel  register-file write address (0 when rf_write_en low)
//   rf_write_en   register-file write strobe
//   lo_load       load LO from the bus
//   hi_load       load HI from the bus

module alu_sequencer #(
  parameter logic [4:0] OP_MUL = 5'd15,
  parameter logic [4:0] OP_DIV = 5'd16,
  parameter logic [4:0] OP_NEG = 5'd17,
  parameter logic [4:0] OP_NOT = 5'd18,
  parameter logic [4:0] OP_MAX = 5'd18
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic [4:0] opcode,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic [3:0] rc,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic [3:0] rf_read_sel,
  output logic       rf_read_en,
  output logic       y_load,
  output logic [4:0] alu_opcode,
  output logic       z_load,
  output logic       z_lo_out,
  output logic       z_hi_out,
  output logic [3:0] rf_write_sel,
  output logic       rf_write_en,
  output logic       lo_load,
  output logic       hi_load
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_Y = 3'd1,
    EXEC   = 3'd2,
    WB_LO  = 3'd3,
    WB_HI  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] op_q;
  logic [3:0] ra_q;
  logic [3:0] rb_q;
  logic [3:0] rc_q;

  // Classification of the incoming opcode (used only for the IDLE branch).
  logic in_illegal;
  logic in_unary;

  // Classification of the latched opcode (drives everything after accept).
  logic q_illegal;
  logic q_unary;
  logic q_wide;

  assign in_illegal = (opcode > OP_MAX);
  assign in_unary   = (opcode == OP_NEG) || (opcode == OP_NOT);

  assign q_illegal  = (op_q > OP_MAX);
  assign q_unary    = (op_q == OP_NEG) || (op_q == OP_NOT);
  assign q_wide     = (op_q == OP_MUL) || (op_q == OP_DIV);

  // The ALU opcode is simply the latched opcode: it only moves on accept.
  assign alu_opcode = op_q;

  // State register and instruction latch. Fields are captured only on the
  // accepting edge, so input changes in flight never reach the datapath.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= IDLE;
      op_q  <= 5'd0;
      ra_q  <= 4'd0;
      rb_q  <= 4'd0;
      rc_q  <= 4'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        op_q <= opcode;
        ra_q <= ra;
        rb_q <= rb;
        rc_q <= rc;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (in_illegal)    state_next = DONE;
          else if (in_unary) state_next = EXEC;
          else               state_next = LOAD_Y;
        end
      end
      LOAD_Y:  state_next = EXEC;
      EXEC:    state_next = WB_LO;
      WB_LO:   state_next = q_wide ? WB_HI : DONE;
      WB_HI:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore output decode. Exactly one bus driver per state at most:
  // rf_read_en in LOAD_Y/EXEC, z_lo_out in WB_LO, z_hi_out in WB_HI.
  always_comb begin
    busy         = (state != IDLE);
    done         = 1'b0;
    illegal      = 1'b0;
    rf_read_sel  = 4'd0;
    rf_read_en   = 1'b0;
    y_load       = 1'b0;
    z_load       = 1'b0;
    z_lo_out     = 1'b0;
    z_hi_out     = 1'b0;
    rf_write_sel = 4'd0;
    rf_write_en  = 1'b0;
    lo_load      = 1'b0;
    hi_load      = 1'b0;
    case (state)
      LOAD_Y: begin
        // Multiply/divide take their first operand from the ra field.
        rf_read_en  = 1'b1;
        y_load      = 1'b1;
        rf_read_sel = q_wide ? ra_q : rb_q;
      end
      EXEC: begin
        rf_read_en  = 1'b1;
        z_load      = 1'b1;
        rf_read_sel = (q_unary || q_wide) ? rb_q : rc_q;
      end
      WB_LO: begin
        z_lo_out = 1'b1;
        if (q_wide) begin
          lo_load = 1'b1;
        end else begin
          rf_write_en  = 1'b1;
          rf_write_sel = ra_q;
        end
      end
      WB_HI: begin
        z_hi_out = 1'b1;
        hi_load  = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        illegal = q_illegal;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Self-checking bench for alu_sequencer. A reference model builds, for each
// accepted instruction, the list of per-cycle output values it should
// produce (fetch / execute / writeback phases / done), and each test task
// compares the DUT cycle by cycle against that list.

module tb_alu_sequencer;

  localparam logic [4:0] OP_MUL = 5'd15;
  localparam logic [4:0] OP_DIV = 5'd16;
  localparam logic [4:0] OP_NEG = 5'd17;
  localparam logic [4:0] OP_NOT = 5'd18;
  localparam logic [4:0] OP_MAX = 5'd18;

  logic       clock = 1'b0;
  logic       clear;
  logic       start;
  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       busy;
  logic       done;
  logic       illegal;
  logic [3:0] rf_read_sel;
  logic       rf_read_en;
  logic       y_load;
  logic [4:0] alu_opcode;
  logic       z_load;
  logic       z_lo_out;
  logic       z_hi_out;
  logic [3:0] rf_write_sel;
  logic       rf_write_en;
  logic       lo_load;
  logic       hi_load;

  alu_sequencer dut (
    .clock        (clock),
    .clear        (clear),
    .start        (start),
    .opcode       (opcode),
    .ra           (ra),
    .rb           (rb),
    .rc           (rc),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal),
    .rf_read_sel  (rf_read_sel),
    .rf_read_en   (rf_read_en),
    .y_load       (y_load),
    .alu_opcode   (alu_opcode),
    .z_load       (z_load),
    .z_lo_out     (z_lo_out),
    .z_hi_out     (z_hi_out),
    .rf_write_sel (rf_write_sel),
    .rf_write_en  (rf_write_en),
    .lo_load      (lo_load),
    .hi_load      (hi_load)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       illegal;
    logic [3:0] rf_read_sel;
    logic       rf_read_en;
    logic       y_load;
    logic [4:0] alu_opcode;
    logic       z_load;
    logic       z_lo_out;
    logic       z_hi_out;
    logic [3:0] rf_write_sel;
    logic       rf_write_en;
    logic       lo_load;
    logic       hi_load;
  } outs_t;

  int         checks   = 0;
  int         failures = 0;
  outs_t      exp_tr [8];
  int         exp_len;
  logic [4:0] model_alu_op = 5'd0;
  outs_t      obs;

  function automatic outs_t sample_outs();
    outs_t o;
    o.busy         = busy;
    o.done         = done;
    o.illegal      = illegal;
    o.rf_read_sel  = rf_read_sel;
    o.rf_read_en   = rf_read_en;
    o.y_load       = y_load;
    o.alu_opcode   = alu_opcode;
    o.z_load       = z_load;
    o.z_lo_out     = z_lo_out;
    o.z_hi_out     = z_hi_out;
    o.rf_write_sel = rf_write_sel;
    o.rf_write_en  = rf_write_en;
    o.lo_load      = lo_load;
    o.hi_load      = hi_load;
    return o;
  endfunction

  // Idle: nothing asserted, ALU opcode keeps the last accepted value.
  function automatic outs_t idle_outs();
    outs_t o;
    o = '0;
    o.alu_opcode = model_alu_op;
    return o;
  endfunction

  // Reference model: the instruction's phase list, one entry per cycle
  // after the accepting edge, ending with the done cycle.
  function automatic void build_trace(input logic [4:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c);
    outs_t base;
    int    n;
    bit    is_ill;
    bit    unary;
    bit    wide;
    is_ill = (op > OP_MAX);
    unary  = (op == OP_NEG) || (op == OP_NOT);
    wide   = (op == OP_MUL) || (op == OP_DIV);
    model_alu_op = op;
    base = '0;
    base.busy = 1'b1;
    base.alu_opcode = op;
    n = 0;
    if (!is_ill) begin
      if (!unary) begin
        exp_tr[n] = base;
        exp_tr[n].rf_read_en  = 1'b1;
        exp_tr[n].y_load      = 1'b1;
        exp_tr[n].rf_read_sel = wide ? a : b;
        n++;
      end
      exp_tr[n] = base;
      exp_tr[n].rf_read_en  = 1'b1;
      exp_tr[n].z_load      = 1'b1;
      exp_tr[n].rf_read_sel = (unary || wide) ? b : c;
      n++;
      exp_tr[n] = base;
      exp_tr[n].z_lo_out = 1'b1;
      if (wide) begin
        exp_tr[n].lo_load = 1'b1;
      end else begin
        exp_tr[n].rf_write_en  = 1'b1;
        exp_tr[n].rf_write_sel = a;
      end
      n++;
      if (wide) begin
        exp_tr[n] = base;
        exp_tr[n].z_hi_out = 1'b1;
        exp_tr[n].hi_load  = 1'b1;
        n++;
      end
    end
    exp_tr[n] = base;
    exp_tr[n].done    = 1'b1;
    exp_tr[n].illegal = is_ill;
    n++;
    exp_len = n;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present an instruction, let the accepting edge pass, and optionally
  // keep start asserted afterwards.
  task automatic applyStimulus(input logic [4:0] op, input logic [3:0] a,
                               input logic [3:0] b, input logic [3:0] c,
                               input bit hold_start);
    opcode = op;
    ra     = a;
    rb     = b;
    rc     = c;
    start  = 1'b1;
    build_trace(op, a, b, c);
    step();
    if (!hold_start) start = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    start = 1'b1;
    opcode = 5'd3;
    step();
    step();
    model_alu_op = 5'd0;
    obs = sample_outs();
    checks++;
    if (obs !== idle_outs())
      $display("FAIL reset got=%h exp=%h", obs, idle_outs());
    if (obs !== idle_outs()) failures++;
    start = 1'b0;
    clear = 1'b1;
    step();
    obs = sample_outs();
    checks++;
    if (obs !== idle_outs()) begin
      $display("FAIL reset_release got=%h exp=%h", obs, idle_outs());
      failures++;
    end
  endtask

  task automatic test_binary();
    applyStimulus(5'd0, 4'd3, 4'd1, 4'd2, 1'b0);
    for (int i = 0; i < exp_len; i++) begin
      obs = sample_outs();
      checks++;
      if (obs !== exp_tr[i]) begin
        $display("FAIL binary cyc%0d got=%h exp=%h", i + 1, obs, exp_tr[i]);
        failures++;
      end
      step();
    end
    obs = sample_outs();
    checks++;
    if (obs !== idle_outs()) begin
      $display("FAIL binary_idle got=%h exp=%h", obs, idle_outs());
      failures++;
    end
  endtask

  task automatic test_mul();
    applyStimulus(OP_MUL, 4'd4, 4'd5, 4'd9, 1'b0);
    for (int i = 0; i < exp_len; i++) begin
      obs = sample_outs();
      checks++;
      if (obs !== exp_tr[i]) begin
        $display("FAIL mul cyc%0d got=%h exp=%h", i + 1, obs, exp_tr[i]);
        failures++;
      end
      step();
    end
    obs = sample_outs();
    checks++;
    if (obs !== idle_outs()) begin
      $display("FAIL mul_idle got=%h exp=%h", obs, idle_outs());
      failures++;
    end
  endtask

  task automatic test_unary();
    applyStimulus(OP_NEG, 4'd6, 4'd7, 4'd1, 1'b0);
    for (int i = 0; i < exp_len; i++) begin
      obs = sample_outs();
      checks++;
      if (obs !== exp_tr[i]) begin
        $display("FAIL unary cyc%0d got=%h exp=%h", i + 1, obs, exp_tr[i]);
        failures++;
      end
      step();
    end
    obs = sample_outs();
    checks++;
    if (obs !== idle_outs()) begin
      $display("FAIL unary_idle got=%h exp=%h", obs, idle_outs());
      failures++;
    end
  endtask

  task automatic test_illegal();
    applyStimulus(5'd25, 4'd2, 4'd3, 4'd4, 1'b0);
    for (int i = 0; i < exp_len; i++) begin
      obs = sample_outs();
      checks++;
      if (obs !== exp_tr[i]) begin
        $display("FAIL illegal cyc%0d got=%h exp=%h", i + 1, obs, exp_tr[i]);
        failures++;
      end
      step();
    end
    obs = sample_outs();
    checks++;
    if (obs !== idle_outs()) begin
      $display("FAIL illegal_idle got=%h exp=%h", obs, idle_outs());
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(5'd7, 4'd2, 4'd3, 4'd4, 1'b1);
    // Second instruction presented while the first is still in flight.
    opcode = OP_MUL;
    ra     = 4'd12;
    rb     = 4'd13;
    rc     = 4'd14;
    for (int i = 0; i < exp_len; i++) begin
      obs = sample_outs();
      checks++;
      if (obs !== exp_tr[i]) begin
        $display("FAIL b2b_first cyc%0d got=%h exp=%h", i + 1, obs, exp_tr[i]);
        failures++;
      end
      checks++;
      if (int'(rf_read_en) + int'(z_lo_out) + int'(z_hi_out) > 1) begin
        $display("FAIL b2b_bus_excl cyc%0d got=%0d exp<=1", i + 1,
                 int'(rf_read_en) + int'(z_lo_out) + int'(z_hi_out));
        failures++;
      end
      step();
    end
    obs = sample_outs();
    checks++;
    if (obs !== idle_outs()) begin
      $display("FAIL b2b_gap got=%h exp=%h", obs, idle_outs());
      failures++;
    end
    build_trace(OP_MUL, 4'd12, 4'd13, 4'd14);
    step();
    start = 1'b0;
    for (int i = 0; i < exp_len; i++) begin
      obs = sample_outs();
      checks++;
      if (obs !== exp_tr[i]) begin
        $display("FAIL b2b_second cyc%0d got=%h exp=%h", i + 1, obs, exp_tr[i]);
        failures++;
      end
      checks++;
      if (int'(rf_read_en) + int'(z_lo_out) + int'(z_hi_out) > 1) begin
        $display("FAIL b2b_bus_excl2 cyc%0d got=%0d exp<=1", i + 1,
                 int'(rf_read_en) + int'(z_lo_out) + int'(z_hi_out));
        failures++;
      end
      step();
    end
    obs = sample_outs();
    checks++;
    if (obs !== idle_outs()) begin
      $display("FAIL b2b_idle got=%h exp=%h", obs, idle_outs());
      failures++;
    end
  endtask

  task automatic test_clear_midflight();
    applyStimulus(5'd3, 4'd9, 4'd10, 4'd11, 1'b0);
    for (int i = 0; i < 2; i++) begin
      obs = sample_outs();
      checks++;
      if (obs !== exp_tr[i]) begin
        $display("FAIL clr_pre cyc%0d got=%h exp=%h", i + 1, obs, exp_tr[i]);
        failures++;
      end
      if (i == 0) step();
    end
    // Now in EXEC: pull clear low across the next edge.
    clear = 1'b0;
    step();
    clear = 1'b1;
    model_alu_op = 5'd0;
    for (int i = 0; i < 3; i++) begin
      obs = sample_outs();
      checks++;
      if (obs !== idle_outs()) begin
        $display("FAIL clr_abort cyc%0d got=%h exp=%h", i, obs, idle_outs());
        failures++;
      end
      step();
    end
    applyStimulus(5'd4, 4'd8, 4'd5, 4'd6, 1'b0);
    for (int i = 0; i < exp_len; i++) begin
      obs = sample_outs();
      checks++;
      if (obs !== exp_tr[i]) begin
        $display("FAIL clr_after cyc%0d got=%h exp=%h", i + 1, obs, exp_tr[i]);
        failures++;
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [4:0] op;
    int gap;
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        obs = sample_outs();
        checks++;
        if (obs !== idle_outs()) begin
          $display("FAIL rand_gap n%0d got=%h exp=%h", n, obs, idle_outs());
          failures++;
        end
        step();
      end
      case ($urandom_range(0, 4))
        0:       op = OP_MUL;
        1:       op = OP_DIV;
        2:       op = OP_NOT;
        default: op = 5'($urandom_range(0, 31));
      endcase
      applyStimulus(op, 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      for (int i = 0; i < exp_len; i++) begin
        obs = sample_outs();
        checks++;
        if (obs !== exp_tr[i]) begin
          $display("FAIL rand n%0d op%0d cyc%0d got=%h exp=%h", n, op, i + 1, obs, exp_tr[i]);
          failures++;
        end
        checks++;
        if (int'(rf_read_en) + int'(z_lo_out) + int'(z_hi_out) > 1) begin
          $display("FAIL rand_bus_excl n%0d got=%0d exp<=1", n,
                   int'(rf_read_en) + int'(z_lo_out) + int'(z_hi_out));
          failures++;
        end
        // Inputs in flight are noise the sequencer must ignore.
        start  = 1'($urandom);
        opcode = 5'($urandom);
        ra     = 4'($urandom);
        rb     = 4'($urandom);
        rc     = 4'($urandom);
        step();
      end
      start = 1'b0;
      obs = sample_outs();
      checks++;
      if (obs !== idle_outs()) begin
        $display("FAIL rand_idle n%0d got=%h exp=%h", n, obs, idle_outs());
        failures++;
      end
    end
  endtask

  initial begin
    clear  = 1'b0;
    start  = 1'b0;
    opcode = 5'd0;
    ra     = 4'd0;
    rb     = 4'd0;
    rc     = 4'd0;
    test_reset();
    test_binary();
    test_mul();
    test_unary();
    test_illegal();
    test_back_to_back();
    test_clear_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control sequencer for the ALU register-transfer instructions.
- Accepts one decoded instruction (opcode, Ra/Rb/Rc fields) on a start handshake.
- Steps the shared-bus datapath through operand fetch into Y, the ALU execute into Z, and writeback of Z to the register file or to HI/LO.
- Sits between the instruction decoder and the datapath control strobes; at most one instruction is in flight.

Parameters:
- OP_MUL, 5'd15, opcode of multiply (64-bit result, writes LO then HI).
- OP_DIV, 5'd16, opcode of divide (quotient to LO, remainder to HI).
- OP_NEG, 5'd17, unary negate (Rb operand only).
- OP_NOT, 5'd18, unary not (Rb operand only).
- OP_MAX, 5'd18, highest legal ALU opcode; above this is illegal.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous, active-low reset.
- start  in  1  request to execute; accepted only in IDLE.
- opcode  in  5  ALU opcode, same encoding as the ALU opcode input.
- ra  in  4  destination register field.
- rb  in  4  source 1 register field.
- rc  in  4  source 2 register field.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  qualifies done; opcode was above OP_MAX.
- rf_read_sel  out  4  register driven onto the bus.
- rf_read_en  out  1  register-file bus drive enable.
- y_load  out  1  load Y from the bus.
- alu_opcode  out  5  opcode presented to the ALU.
- z_load  out  1  load Z (64-bit) from the ALU result.
- z_lo_out  out  1  drive Z[31:0] onto the bus.
- z_hi_out  out  1  drive Z[63:32] onto the bus.
- rf_write_sel  out  4  register-file write address.
- rf_write_en  out  1  register-file write strobe.
- lo_load  out  1  load LO from the bus.
- hi_load  out  1  load HI from the bus.

Behaviour:
- State register: IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, DONE.
- All outputs are Moore-decoded from the state register and the latched fields. Only one bus driver (rf_read_en, z_lo_out, z_hi_out) is active in any cycle.
- Reset (clear=0 at a rising edge):
  - state goes to IDLE; latched fields and alu_opcode go to 0.
  - Every strobe plus busy, done and illegal are 0 from the following cycle.
  - Reset mid-operation aborts with no further writes. A write strobe already issued in the same cycle as the clear edge is not suppressed retroactively.
- Accept: in IDLE with start=1, latch opcode/ra/rb/rc at the edge. Inputs are ignored afterward. start while busy=1 (including DONE) is ignored, not queued.
- Transitions from IDLE on accept:
  - Binary op (opcode not OP_NEG/OP_NOT, and not above OP_MAX): to LOAD_Y.
  - Unary op: to EXEC.
  - Illegal op: to DONE.
- LOAD_Y:
  - rf_read_en=1, y_load=1.
  - rf_read_sel=rb, or ra for OP_MUL/OP_DIV.
  - Next state EXEC.
- EXEC:
  - rf_read_en=1, z_load=1, alu_opcode=latched opcode.
  - rf_read_sel=rc for binary ops; rb for unary ops and for OP_MUL/OP_DIV.
  - Next state WB_LO.
- WB_LO:
  - z_lo_out=1.
  - Normal ops: rf_write_en=1, rf_write_sel=ra, next state DONE.
  - OP_MUL/OP_DIV: lo_load=1, rf_write_en=0, next state WB_HI.
- WB_HI: z_hi_out=1, hi_load=1, next state DONE.
- DONE:
  - done=1; illegal=1 only for the illegal path.
  - Next state IDLE unconditionally.
- alu_opcode holds its last latched value outside EXEC. It changes only on accept.
- rf_read_sel and rf_write_sel are 0 when their enables are low.
- Latency from the accepting edge to the done cycle:
  - Binary: 4 cycles (done in 4th cycle after accept).
  - Unary: 3 cycles.
  - MUL/DIV: 5 cycles.
  - Illegal: 1 cycle.
- Minimum spacing between accepts is latency+1 cycles, because start is only seen in IDLE.

Test Plan:
- Reset, then start with opcode=0, ra=3, rb=1, rc=2 -> LOAD_Y drives sel=1 with y_load; EXEC drives sel=2 with z_load and alu_opcode=0; WB_LO has rf_write_en with sel=3 and z_lo_out; done pulses 4 cycles after accept; busy=1 for exactly 4 cycles.
- OP_MUL with ra=4, rb=5 -> LOAD_Y reads sel 4, EXEC reads sel 5, WB_LO has lo_load with z_lo_out, WB_HI has hi_load with z_hi_out; rf_write_en never asserts; done 5 cycles after accept.
- OP_NEG with ra=6, rb=7 -> no y_load; EXEC reads sel 7 with alu_opcode=17; WB_LO writes r6; done 3 cycles after accept.
- opcode=5'd25 -> DONE the next cycle with done=1 and illegal=1; no read, load or write strobe ever asserts.
- Hold start=1 continuously, changing opcode/ra in mid-flight -> second accept only in the cycle after DONE; first instruction uses its latched fields; bus drivers are never simultaneously active (checked each cycle).
- Assert clear=0 during EXEC of a binary op -> next cycle IDLE, all strobes and busy 0, no rf_write_en; a start after release executes normally.
